alu_src_seq: RTL

- Multi-cycle execute sequencer for the 8-bit R.O.E datapath.
- Accepts one 9-bit instruction at a time over a valid/ready handshake and decodes it.
- Drives the ALU-source mux select and operand fields (extend-immediate, increment input), the ALU op, and the write enables, state by state.
- Owns the repeat-increment loop counter; sits between instruction fetch and the ALU/register file.

---
 rtl/alu_src_seq.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/alu_src_seq.sv
// Multi-cycle execute sequencer for the 8-bit R.O.E datapath: accepts one instruction,
// decodes it and steps the ALU source mux, operands, ALU op and write strobes.
module alu_src_seq #(
  parameter int IW   = 9,
  parameter int IMMW = 4,
  parameter int DW   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IW-1:0]   instr_i,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  output logic [1:0]      alu_src_o,
  output logic [IMMW-1:0] to_ext_o,
  output logic [IMMW-1:0] to_inc_o,
  output logic [2:0]      alu_op_o,
  output logic [1:0]      rd_idx_o,
  output logic            acc_we_o,
  output logic            reg_we_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic            halted_o
);

  // state  | meaning
  // IDLE   | waiting for an instruction, instr_ready high
  // DECODE | latched op examined, next state chosen
  // EXEC   | single ALU operation into the accumulator
  // REPEAT | increment loop, one accumulator write per count
  // WB     | register-file write and done pulse
  // HALT   | parked until reset
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_REPEAT = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [2:0] OP_ADDI  = 3'b000;
  localparam logic [2:0] OP_INC   = 3'b001;
  localparam logic [2:0] OP_ADDR  = 3'b010;
  localparam logic [2:0] OP_REP   = 3'b011;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] SRC_EXT  = 2'b00;
  localparam logic [1:0] SRC_INC  = 2'b01;
  localparam logic [1:0] SRC_REG  = 2'b10;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_PASS = 3'b001;

  state_e state_q, state_d;

  logic [2:0]      op_q;
  logic [IMMW-1:0] imm_q;
  logic [1:0]      idx_q;
  logic [IMMW-1:0] rep_cnt_q, rep_cnt_d;
  logic            rep_last;
  logic            dec_illegal;
  logic            accept;

  logic            ready_q,   ready_d;
  logic [1:0]      alu_src_q, alu_src_d;
  logic [IMMW-1:0] to_ext_q,  to_ext_d;
  logic [IMMW-1:0] to_inc_q,  to_inc_d;
  logic [2:0]      alu_op_q,  alu_op_d;
  logic [1:0]      rd_idx_q,  rd_idx_d;
  logic            acc_we_q,  acc_we_d;
  logic            reg_we_q,  reg_we_d;
  logic            busy_q,    busy_d;
  logic            done_q,    done_d;
  logic            err_q,     err_d;
  logic            halted_q,  halted_d;

  assign accept = ready_q & instr_valid_i;

  // Compared at datapath width so imm = all-ones still terminates without wrap
  assign rep_last = (DW'(rep_cnt_q) + DW'(1)) == DW'(imm_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rep_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rep_cnt_d   = rep_cnt_q;
    err_d       = err_q;
    dec_illegal = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (op_q)
          OP_ADDI, OP_INC, OP_ADDR: state_d = S_EXEC;
          OP_REP:  state_d = (imm_q == '0) ? S_WB : S_REPEAT;
          OP_HALT: state_d = S_HALT;
          default: begin
            state_d     = S_IDLE;
            err_d       = 1'b1;
            dec_illegal = 1'b1;
          end
        endcase
      end
      S_EXEC:   state_d = S_WB;
      S_REPEAT: begin
        if (rep_last) begin
          state_d   = S_WB;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + IMMW'(1);
        end
      end
      S_WB:     state_d = S_IDLE;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state and registered, so each
  // strobe lines up with the cycle its state is occupied.
  always_comb begin
    ready_d   = (state_d == S_IDLE);
    alu_src_d = SRC_REG;
    to_ext_d  = '0;
    to_inc_d  = '0;
    alu_op_d  = ALU_ADD;
    rd_idx_d  = '0;
    acc_we_d  = 1'b0;
    reg_we_d  = 1'b0;
    busy_d    = (state_d == S_DECODE) || (state_d == S_EXEC) ||
                (state_d == S_REPEAT) || (state_d == S_WB);
    done_d    = dec_illegal;
    halted_d  = 1'b0;
    case (state_d)
      S_EXEC: begin
        alu_op_d = ALU_ADD;
        acc_we_d = 1'b1;
        rd_idx_d = idx_q;
        case (op_q)
          OP_ADDI: begin
            alu_src_d = SRC_EXT;
            to_ext_d  = imm_q;
          end
          OP_INC: begin
            alu_src_d = SRC_INC;
            to_inc_d  = imm_q;
          end
          default: alu_src_d = SRC_REG;
        endcase
      end
      S_REPEAT: begin
        alu_src_d = SRC_INC;
        to_inc_d  = rep_cnt_d;
        alu_op_d  = ALU_PASS;
        acc_we_d  = 1'b1;
      end
      S_WB: begin
        reg_we_d = 1'b1;
        rd_idx_d = idx_q;
        done_d   = 1'b1;
      end
      S_HALT: halted_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q   <= 1'b1;
      alu_src_q <= SRC_REG;
      to_ext_q  <= '0;
      to_inc_q  <= '0;
      alu_op_q  <= ALU_ADD;
      rd_idx_q  <= '0;
      acc_we_q  <= 1'b0;
      reg_we_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      ready_q   <= ready_d;
      alu_src_q <= alu_src_d;
      to_ext_q  <= to_ext_d;
      to_inc_q  <= to_inc_d;
      alu_op_q  <= alu_op_d;
      rd_idx_q  <= rd_idx_d;
      acc_we_q  <= acc_we_d;
      reg_we_q  <= reg_we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      halted_q  <= halted_d;
    end
  end

  // Instruction fields are captured only on the accepting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      imm_q <= '0;
      idx_q <= '0;
    end else if (accept) begin
      op_q  <= instr_i[IW-1 -: 3];
      imm_q <= instr_i[IMMW+1:2];
      idx_q <= instr_i[1:0];
    end
  end

  assign instr_ready_o = ready_q;
  assign alu_src_o     = alu_src_q;
  assign to_ext_o      = to_ext_q;
  assign to_inc_o      = to_inc_q;
  assign alu_op_o      = alu_op_q;
  assign rd_idx_o      = rd_idx_q;
  assign acc_we_o      = acc_we_q;
  assign reg_we_o      = reg_we_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign halted_o      = halted_q;

endmodule
